// File: rtl/irq_ack_pkg.sv
// Shared types and constants for the CPU-side interrupt acknowledge sequencer.
package irq_ack_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INTA1,
      GAP,
      INTA2,
      HOLD,
      RECOVER
   } irq_ack_state_t;

   localparam logic [7:0] DEFAULT_SPURIOUS_VECTOR = 8'h0F;

   function automatic int unsigned max_cycles(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/irq_ack_timer.sv
// Loadable down-counter with a zero flag; times the INTA pulses, the gap and recovery.
module irq_ack_timer #(
   parameter int unsigned WIDTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic             zero
);

   logic [WIDTH-1:0] count_q;

   // Saturates at zero so idle states need no explicit enable.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_value;
      end else if (count_q != '0) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/irq_ack_sequencer.sv
// Drives the two-pulse INTA protocol to an 8259-style PIC, captures the vector byte
// and offers it to the CPU core over a valid/ready handshake.
module irq_ack_sequencer
   import irq_ack_pkg::*;
#(
   parameter int unsigned INTA_LOW_CYCLES = 2,
   parameter int unsigned INTA_GAP_CYCLES = 1,
   parameter logic [7:0]  SPURIOUS_VECTOR = DEFAULT_SPURIOUS_VECTOR
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pic_intr,
   input  logic [7:0] pic_data_in,
   input  logic       pic_data_io,
   output logic       inta_n,
   input  logic       cpu_int_enable,
   input  logic       cpu_boundary,
   output logic [7:0] vector,
   output logic       vector_valid,
   input  logic       vector_ready,
   output logic       busy,
   output logic       spurious
);

   localparam int unsigned CNT_W = $clog2(max_cycles(INTA_LOW_CYCLES, INTA_GAP_CYCLES) + 1);
   localparam logic [CNT_W-1:0] LOW_LOAD = CNT_W'(INTA_LOW_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(INTA_GAP_CYCLES - 1);

   irq_ack_state_t   state_q, state_d;
   logic             timer_load;
   logic [CNT_W-1:0] timer_value;
   logic             timer_zero;

   logic [7:0] vector_q, vector_d;
   logic       spurious_q, spurious_d;
   logic       inta_n_q;
   logic       vector_valid_q;
   logic       busy_q;

   irq_ack_timer #(
      .WIDTH (CNT_W)
   ) u_timer (
      .clk        (clk),
      .reset      (reset),
      .load       (timer_load),
      .load_value (timer_value),
      .zero       (timer_zero)
   );

   // Once INTA1 is entered the sequence always runs to HOLD, whatever the PIC or CPU do.
   always_comb begin
      state_d     = state_q;
      timer_load  = 1'b0;
      timer_value = LOW_LOAD;
      vector_d    = vector_q;
      spurious_d  = spurious_q;
      unique case (state_q)
         IDLE: begin
            if (pic_intr && cpu_int_enable && cpu_boundary) begin
               state_d     = INTA1;
               timer_load  = 1'b1;
               timer_value = LOW_LOAD;
            end
         end
         INTA1: begin
            if (timer_zero) begin
               state_d     = GAP;
               timer_load  = 1'b1;
               timer_value = GAP_LOAD;
            end
         end
         GAP: begin
            if (timer_zero) begin
               state_d     = INTA2;
               timer_load  = 1'b1;
               timer_value = LOW_LOAD;
            end
         end
         INTA2: begin
            if (timer_zero) begin
               state_d = HOLD;
               if (!pic_data_io) begin
                  vector_d   = pic_data_in;
                  spurious_d = 1'b0;
               end else begin
                  vector_d   = SPURIOUS_VECTOR;
                  spurious_d = 1'b1;
               end
            end
         end
         HOLD: begin
            if (vector_ready) begin
               state_d     = RECOVER;
               timer_load  = 1'b1;
               timer_value = GAP_LOAD;
            end
         end
         RECOVER: begin
            if (timer_zero) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         vector_q       <= 8'h00;
         spurious_q     <= 1'b0;
         inta_n_q       <= 1'b1;
         vector_valid_q <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         vector_q       <= vector_d;
         spurious_q     <= spurious_d;
         inta_n_q       <= !((state_d == INTA1) || (state_d == INTA2));
         vector_valid_q <= (state_d == HOLD);
         busy_q         <= (state_d != IDLE);
      end
   end

   assign inta_n       = inta_n_q;
   assign vector       = vector_q;
   assign vector_valid = vector_valid_q;
   assign busy         = busy_q;
   assign spurious     = spurious_q;

endmodule

// File: tb/tb_irq_ack_sequencer.sv
// Directed bench for irq_ack_sequencer: default, SPURIOUS_VECTOR=FF and LOW=1/GAP=3 instances.
module tb_irq_ack_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       pic_intr, pic_data_io, cpu_int_enable, cpu_boundary, vector_ready;
   logic [7:0] pic_data_in;
   logic       inta_n, vector_valid, busy, spurious;
   logic [7:0] vector;
   logic       ff_inta_n, ff_vector_valid, ff_busy, ff_spurious;
   logic [7:0] ff_vector;

   logic       sw_intr, sw_io, sw_en, sw_bnd, sw_ready;
   logic [7:0] sw_data;
   logic       sw_inta_n, sw_valid, sw_busy, sw_spurious;
   logic [7:0] sw_vector;

   logic [7:0] q_vec[$];
   logic       q_sp[$];
   logic [7:0] q_ff[$];
   logic [7:0] q_sw[$];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   irq_ack_sequencer dut (
      .clk            (clk),
      .reset          (reset),
      .pic_intr       (pic_intr),
      .pic_data_in    (pic_data_in),
      .pic_data_io    (pic_data_io),
      .inta_n         (inta_n),
      .cpu_int_enable (cpu_int_enable),
      .cpu_boundary   (cpu_boundary),
      .vector         (vector),
      .vector_valid   (vector_valid),
      .vector_ready   (vector_ready),
      .busy           (busy),
      .spurious       (spurious)
   );

   irq_ack_sequencer #(
      .SPURIOUS_VECTOR (8'hFF)
   ) dut_ff (
      .clk            (clk),
      .reset          (reset),
      .pic_intr       (pic_intr),
      .pic_data_in    (pic_data_in),
      .pic_data_io    (pic_data_io),
      .inta_n         (ff_inta_n),
      .cpu_int_enable (cpu_int_enable),
      .cpu_boundary   (cpu_boundary),
      .vector         (ff_vector),
      .vector_valid   (ff_vector_valid),
      .vector_ready   (vector_ready),
      .busy           (ff_busy),
      .spurious       (ff_spurious)
   );

   irq_ack_sequencer #(
      .INTA_LOW_CYCLES (1),
      .INTA_GAP_CYCLES (3)
   ) dut_sw (
      .clk            (clk),
      .reset          (reset),
      .pic_intr       (sw_intr),
      .pic_data_in    (sw_data),
      .pic_data_io    (sw_io),
      .inta_n         (sw_inta_n),
      .cpu_int_enable (sw_en),
      .cpu_boundary   (sw_bnd),
      .vector         (sw_vector),
      .vector_valid   (sw_valid),
      .vector_ready   (sw_ready),
      .busy           (sw_busy),
      .spurious       (sw_spurious)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Caller has set the start inputs with the DUT in IDLE; the next edge is edge 0.
   task automatic run_seq(input string tag, input logic [7:0] data, input logic io,
                          input int hold, input logic keep_intr, input logic drop_in_gap);
      logic [7:0] exp_vec, exp_ff, got_vec, got_ff;
      logic       exp_sp, got_sp;
      exp_vec = io ? 8'h0F : data;
      exp_ff  = io ? 8'hFF : data;
      exp_sp  = io;
      q_vec.push_back(exp_vec);
      q_sp.push_back(exp_sp);
      q_ff.push_back(exp_ff);
      step();
      chk({tag, "_c1_inta"}, inta_n, 0);
      chk({tag, "_c1_busy"}, busy, 1);
      pic_intr = keep_intr;
      step();
      chk({tag, "_c2_inta"}, inta_n, 0);
      step();
      chk({tag, "_c3_inta"}, inta_n, 1);
      chk({tag, "_c3_busy"}, busy, 1);
      if (drop_in_gap) pic_intr = 1'b0;
      step();
      chk({tag, "_c4_inta"}, inta_n, 0);
      pic_data_in = data;
      pic_data_io = io;
      step();
      chk({tag, "_c5_inta"}, inta_n, 0);
      chk({tag, "_c5_valid"}, vector_valid, 0);
      step();
      chk({tag, "_c6_valid"}, vector_valid, 1);
      chk({tag, "_c6_inta"}, inta_n, 1);
      if (vector_valid === 1'b1 && q_vec.size() > 0) begin
         got_vec = q_vec.pop_front();
         got_sp  = q_sp.pop_front();
         got_ff  = q_ff.pop_front();
         chk({tag, "_vector"}, vector, got_vec);
         chk({tag, "_spurious"}, spurious, got_sp);
         chk({tag, "_ff_vector"}, ff_vector, got_ff);
         chk({tag, "_ff_spurious"}, ff_spurious, got_sp);
      end
      pic_data_io = 1'b1;
      pic_data_in = 8'h00;
      for (int i = 0; i < hold; i++) begin
         step();
         chk({tag, "_hold_valid"}, vector_valid, 1);
         chk({tag, "_hold_vector"}, vector, exp_vec);
      end
      vector_ready = 1'b1;
      step();
      vector_ready = 1'b0;
      chk({tag, "_post_valid"}, vector_valid, 0);
      chk({tag, "_recover_busy"}, busy, 1);
      chk({tag, "_recover_inta"}, inta_n, 1);
   endtask

   initial begin
      logic [9:0] sw_exp_inta;
      logic [9:0] sw_exp_busy;
      sw_exp_inta = 10'b1111101110;
      sw_exp_busy = 10'b0111111111;

      reset = 1'b1;
      pic_intr = 1'b0; pic_data_in = 8'h00; pic_data_io = 1'b1;
      cpu_int_enable = 1'b0; cpu_boundary = 1'b0; vector_ready = 1'b0;
      sw_intr = 1'b0; sw_data = 8'h00; sw_io = 1'b1; sw_en = 1'b0; sw_bnd = 1'b0;
      sw_ready = 1'b0;
      repeat (2) step();
      chk("rst_inta", inta_n, 1);
      chk("rst_vector", vector, 8'h00);
      chk("rst_valid", vector_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_spurious", spurious, 0);
      chk("rst_sw_inta", sw_inta_n, 1);
      chk("rst_sw_busy", sw_busy, 0);
      reset = 1'b0;
      step();
      chk("idle_busy", busy, 0);

      // Basic acknowledge with defaults
      pic_intr = 1'b1; cpu_int_enable = 1'b1; cpu_boundary = 1'b1;
      run_seq("basic", 8'h08, 1'b0, 0, 1'b0, 1'b0);
      step();
      chk("basic_idle_busy", busy, 0);

      // Gating by IF flag, then by instruction boundary
      pic_intr = 1'b1; cpu_int_enable = 1'b0; cpu_boundary = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         chk("gate_en_inta", inta_n, 1);
         chk("gate_en_busy", busy, 0);
      end
      cpu_int_enable = 1'b1; cpu_boundary = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         chk("gate_bnd_inta", inta_n, 1);
         chk("gate_bnd_busy", busy, 0);
      end
      cpu_boundary = 1'b1;

      // PIC leaves the bus undriven on the second pulse
      run_seq("spur", 8'h55, 1'b1, 0, 1'b0, 1'b0);
      step();
      chk("spur_idle_busy", busy, 0);

      // Backpressure, then restart with pic_intr still asserted
      pic_intr = 1'b1;
      run_seq("bp", 8'h21, 1'b0, 10, 1'b1, 1'b0);
      step();
      chk("bp_idle_busy", busy, 0);
      chk("bp_idle_inta", inta_n, 1);
      run_seq("restart", 8'h22, 1'b0, 0, 1'b0, 1'b0);
      step();
      chk("restart_idle_busy", busy, 0);

      // pic_intr dropped during GAP does not abort the sequence
      pic_intr = 1'b1;
      run_seq("gapdrop", 8'h33, 1'b0, 0, 1'b1, 1'b1);
      step();
      chk("gapdrop_idle_busy", busy, 0);

      // Reset during INTA2
      pic_intr = 1'b1;
      step();
      pic_intr = 1'b0;
      step();
      step();
      step();
      chk("mid_c4_inta", inta_n, 0);
      reset = 1'b1;
      #1;
      chk("mid_rst_inta", inta_n, 1);
      chk("mid_rst_valid", vector_valid, 0);
      step();
      reset = 1'b0;
      step();
      chk("mid_rel_busy", busy, 0);
      chk("mid_rel_inta", inta_n, 1);
      step();
      chk("mid_rel_busy2", busy, 0);

      // LOW=1, GAP=3 instance: pulse widths, gap and recovery length
      sw_intr = 1'b1; sw_en = 1'b1; sw_bnd = 1'b1; sw_data = 8'h44; sw_io = 1'b0;
      q_sw.push_back(8'h44);
      for (int c = 1; c <= 10; c++) begin
         step();
         chk($sformatf("sw_c%0d_inta", c), sw_inta_n, {7'd0, sw_exp_inta[c-1]});
         chk($sformatf("sw_c%0d_busy", c), sw_busy, {7'd0, sw_exp_busy[c-1]});
         if (c == 6) begin
            chk("sw_c6_valid", sw_valid, 1);
            if (sw_valid === 1'b1 && q_sw.size() > 0) begin
               chk("sw_vector", sw_vector, q_sw.pop_front());
               chk("sw_spurious", sw_spurious, 0);
            end
            sw_ready = 1'b1;
         end
         if (c == 7) begin
            sw_ready = 1'b0;
            chk("sw_c7_valid", sw_valid, 0);
         end
      end
      step();
      chk("sw_restart_inta", sw_inta_n, 0);
      sw_intr = 1'b0;

      chk("sb_drain", 8'(q_vec.size()), 8'd0);
      chk("sb_sw_drain", 8'(q_sw.size()), 8'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
